// File: rtl/gecko_data_memory.sv
// rtl/gecko_data_memory.sv - byte-maskable word memory with in-order buffered read responses
module gecko_data_memory #(
    parameter int ADDR_WIDTH = 10,
    parameter int RESP_DEPTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_read_enable,
    input  logic [3:0]            i_req_write_mask,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [31:0]           i_req_data,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [31:0]           o_resp_data
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_V  = (CW + 1)'(RESP_DEPTH);

    logic [31:0]   r_mem [2**ADDR_WIDTH];
    logic [31:0]   r_rd_data;
    logic          r_inflight;
    logic [31:0]   r_fifo [RESP_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_occupancy;

    // Reserving a slot for the in-flight read keeps the FIFO from ever overflowing.
    assign w_occupancy  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign o_req_ready  = (w_occupancy < DEPTH_V);
    assign w_accept     = i_req_valid && o_req_ready;
    assign w_push       = r_inflight;
    assign o_resp_valid = (r_count != '0);
    assign w_pop        = o_resp_valid && i_resp_ready;
    assign o_resp_data  = o_resp_valid ? r_fifo[r_rptr] : 32'h0;

    // Non-blocking read of the old word makes a combined read+write read-first.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int i = 0; i < 4; i++) begin
                if (i_req_write_mask[i]) begin
                    r_mem[i_req_addr][8*i +: 8] <= i_req_data[8*i +: 8];
                end
            end
            if (i_req_read_enable) begin
                r_rd_data <= r_mem[i_req_addr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= r_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_accept && i_req_read_enable;
            if (w_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
